fwd_hazard_unit: RTL

- Forwarding and load-use hazard controller for the 5-stage datapath.
- Tracks the destination register of each in-flight instruction through the EX, MEM and WB slots.
- Generates the 2-bit select codes driving the operand-A and operand-B mux41 instances in front of the ALU.
- Asserts a one-cycle stall and injects a bubble into EX on a load-use dependency.

---
 rtl/fwd_pkg.sv | 28 ++
 rtl/fwd_slot_reg.sv | 22 ++
 rtl/fwd_hazard_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and slot field layout for the forwarding / load-use hazard unit.
package fwd_pkg;

    localparam int DEFAULT_REG_ADDR_W = 5;
    localparam int FWD_SEL_W          = 2;

    // Select codes for the mux41 in front of each ALU operand; 2'b11 is unused.
    localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'b10;

    // Control bits carried by every in-flight slot.
    typedef struct packed {
        logic valid;
        logic wr_en;
        logic is_load;
    } slot_ctrl_t;

    // Source-use bits, carried only by the EX slot.
    typedef struct packed {
        logic use_rs;
        logic use_rt;
    } src_ctrl_t;

    localparam int SLOT_CTRL_W = $bits(slot_ctrl_t);
    localparam int SRC_CTRL_W  = $bits(src_ctrl_t);

endpackage

// File: rtl/fwd_slot_reg.sv
// One pipeline slot register: synchronous clear (reset or bubble) beats load.
module fwd_slot_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every slot
    // samples its neighbour's pre-edge value and the shift is race-free.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the 5-stage datapath.
// Optional FWD_STATS_EN adds saturating stall / forward event counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int SEL_W      = FWD_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_wr_addr,
    input  logic                  id_is_load,
    input  logic                  ex_flush,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  stall
`ifdef FWD_STATS_EN
   ,output logic [31:0]           stall_cnt
   ,output logic [31:0]           fwd_cnt
`endif
);

    localparam int EX_W  = SLOT_CTRL_W + SRC_CTRL_W + 3 * REG_ADDR_W;
    localparam int MEM_W = SLOT_CTRL_W + REG_ADDR_W;
    localparam int WB_W  = 2 + REG_ADDR_W;

    slot_ctrl_t            id_ctrl, ex_ctrl, mem_ctrl;
    src_ctrl_t             id_src, ex_src;
    logic [REG_ADDR_W-1:0] ex_wr_addr, ex_rs, ex_rt, mem_wr_addr, wb_wr_addr;
    logic                  wb_valid, wb_wr_en;
    logic [EX_W-1:0]       ex_q;
    logic [MEM_W-1:0]      mem_q;
    logic [WB_W-1:0]       wb_q;
    logic                  load_use, bubble;

    assign id_ctrl = '{valid: id_valid, wr_en: id_wr_en, is_load: id_is_load};
    assign id_src  = '{use_rs: id_use_rs, use_rt: id_use_rt};

    fwd_slot_reg #(.W(EX_W)) u_ex_slot (
        .clk  (clk),
        .clr  (rst | bubble),
        .load (1'b1),
        .d    ({id_ctrl, id_src, id_wr_addr, id_rs, id_rt}),
        .q    (ex_q)
    );

    fwd_slot_reg #(.W(MEM_W)) u_mem_slot (
        .clk  (clk),
        .clr  (rst),
        .load (1'b1),
        .d    ({ex_ctrl, ex_wr_addr}),
        .q    (mem_q)
    );

    // WB forwarding ignores is_load, so the WB slot does not keep it.
    fwd_slot_reg #(.W(WB_W)) u_wb_slot (
        .clk  (clk),
        .clr  (rst),
        .load (1'b1),
        .d    ({mem_ctrl.valid, mem_ctrl.wr_en, mem_wr_addr}),
        .q    (wb_q)
    );

    assign {ex_ctrl, ex_src, ex_wr_addr, ex_rs, ex_rt} = ex_q;
    assign {mem_ctrl, mem_wr_addr}                     = mem_q;
    assign {wb_valid, wb_wr_en, wb_wr_addr}            = wb_q;

    // A producer slot matches a consumer source; register 0 never matches.
    function automatic logic src_hit(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  valid,
        input logic                  wr_en,
        input logic [REG_ADDR_W-1:0] wr_addr
    );
        return use_src & valid & wr_en & (wr_addr != '0) & (wr_addr == src);
    endfunction

    assign load_use = src_hit(id_use_rs, id_rs, ex_ctrl.valid & ex_ctrl.is_load,
                              ex_ctrl.wr_en, ex_wr_addr)
                    | src_hit(id_use_rt, id_rt, ex_ctrl.valid & ex_ctrl.is_load,
                              ex_ctrl.wr_en, ex_wr_addr);

    // A flush kills the dependent instruction, so there is nothing to hold.
    assign stall  = id_valid & load_use & ~ex_flush;
    assign bubble = stall | ex_flush;

    // NOTE: every always_comb output gets its default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        fwd_a_sel = SEL_W'(FWD_RF);
        fwd_b_sel = SEL_W'(FWD_RF);
        if (ex_ctrl.valid) begin
            if (src_hit(ex_src.use_rs, ex_rs, mem_ctrl.valid, mem_ctrl.wr_en, mem_wr_addr)
                && !mem_ctrl.is_load) begin
                fwd_a_sel = SEL_W'(FWD_MEM);
            end else if (src_hit(ex_src.use_rs, ex_rs, wb_valid, wb_wr_en, wb_wr_addr)) begin
                fwd_a_sel = SEL_W'(FWD_WB);
            end

            if (src_hit(ex_src.use_rt, ex_rt, mem_ctrl.valid, mem_ctrl.wr_en, mem_wr_addr)
                && !mem_ctrl.is_load) begin
                fwd_b_sel = SEL_W'(FWD_MEM);
            end else if (src_hit(ex_src.use_rt, ex_rt, wb_valid, wb_wr_en, wb_wr_addr)) begin
                fwd_b_sel = SEL_W'(FWD_WB);
            end
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((fwd_a_sel != '0 || fwd_b_sel != '0) && fwd_cnt != '1) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
